sdrd_deserializer: RTL and testbench

- Downstream consumer of the SDRD serial read stream produced by the serial-read state machine on the card.
- Samples SDRD once per clock while the serial-read window is open, assembles BITS-wide words and presents each word to the host-side bus logic over a valid/ack handshake.
- Flags words lost to host back-pressure (overrun) and discards partial words when the window closes early (abort).

---
 rtl/sdrd_deserializer.sv | 146 ++++++++++++++
 tb/tb_sdrd_deserializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sdrd_deserializer.sv
// sdrd_deserializer
//   Collects the SDRD serial read stream into BITS-wide words. A bit is taken
//   on every clock where the serial-read window is open. Each finished word is
//   handed to the host-side bus logic over a valid/ack handshake.
//
//   Ports
//     clk, rst          clock; synchronous active-high reset
//     sser              serial select, active low
//     ba13, ba12, br_w  bus address bits / read qualifier that form the window
//     sdrd              serial read data bit
//     data_ack          host accepts data_out (ignored while data_valid = 0)
//     ovr_clr           clears the sticky overrun flag
//     data_out          last completed word
//     data_valid        data_out holds a word the host has not yet accepted
//     overrun           sticky; a completed word was dropped
//     abort             one-cycle pulse; a partial word was discarded
//     busy              FSM is in SHIFT
module sdrd_deserializer #(
   parameter int BITS      = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sser,
   input  logic            ba13,
   input  logic            ba12,
   input  logic            br_w,
   input  logic            sdrd,
   input  logic            data_ack,
   input  logic            ovr_clr,
   output logic [BITS-1:0] data_out,
   output logic            data_valid,
   output logic            overrun,
   output logic            abort,
   output logic            busy
);

   localparam int            CW   = $clog2(BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [BITS-1:0] shreg, shreg_nxt, shifted;
   logic            win, done, abort_nxt, ovr_set;

   assign win  = ~sser & ~ba13 & ba12 & br_w;
   assign busy = (state == SHIFT);

   // Shift register with the current bit inserted. Once a full word has been
   // shifted in, any older contents have been pushed out, so the register
   // never has to be cleared between back-to-back words.
   always_comb begin
      if (MSB_FIRST) begin
         shifted    = shreg << 1;
         shifted[0] = sdrd;
      end else begin
         shifted           = shreg >> 1;
         shifted[BITS-1]   = sdrd;
      end
   end

   // After a word completes the FSM stays in SHIFT with cnt = 0. A closing
   // window at that point is a clean boundary, so it does not abort.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      done      = 1'b0;
      abort_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (win) begin
               shreg_nxt = shifted;
               state_nxt = SHIFT;
               if (cnt == LAST) begin
                  done    = 1'b1;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         SHIFT: begin
            if (win) begin
               shreg_nxt = shifted;
               if (cnt == LAST) begin
                  done    = 1'b1;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               shreg_nxt = '0;
               abort_nxt = (cnt != '0);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A word that completes while the previous one is still pending and
   // unacknowledged is lost.
   assign ovr_set = done & data_valid & ~data_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         abort      <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         shreg <= shreg_nxt;
         abort <= abort_nxt;
         if (done) begin
            // An ack on the completion edge frees the slot for the new word.
            if (!data_valid || data_ack) begin
               data_out   <= shifted;
               data_valid <= 1'b1;
            end
         end else if (data_valid && data_ack) begin
            data_valid <= 1'b0;
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sdrd_deserializer.sv
module tb_sdrd_deserializer;
   localparam int BITS = 8;

   logic clk = 1'b0;
   logic rst, sser, ba13, ba12, br_w, sdrd, data_ack, ovr_clr;
   logic [BITS-1:0] dm, dl;
   logic vm, vl, om, ol, am, al, bm, bl;

   int n_chk = 0;
   int n_fail = 0;

   sdrd_deserializer #(.BITS(BITS), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .sser(sser), .ba13(ba13), .ba12(ba12), .br_w(br_w),
      .sdrd(sdrd), .data_ack(data_ack), .ovr_clr(ovr_clr),
      .data_out(dm), .data_valid(vm), .overrun(om), .abort(am), .busy(bm));

   sdrd_deserializer #(.BITS(BITS), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .sser(sser), .ba13(ba13), .ba12(ba12), .br_w(br_w),
      .sdrd(sdrd), .data_ack(data_ack), .ovr_clr(ovr_clr),
      .data_out(dl), .data_valid(vl), .overrun(ol), .abort(al), .busy(bl));

   always #5 clk = ~clk;

   // Reference model: bits of the current word collected in a queue; a word
   // is formed when BITS bits are present. busy follows the previous cycle's
   // window since any sampled bit leaves the deserializer shifting.
   bit             q[$];
   logic [BITS-1:0] e_dm, e_dl;
   logic            e_v, e_ovr, e_abort, e_busy;

   always @(posedge clk) begin
      logic w, done;
      logic [BITS-1:0] wm, wl;
      w = ~sser & ~ba13 & ba12 & br_w;
      done = 1'b0;
      wm = '0;
      wl = '0;
      if (rst) begin
         q.delete();
         e_dm = '0; e_dl = '0; e_v = 1'b0; e_ovr = 1'b0; e_abort = 1'b0; e_busy = 1'b0;
      end else begin
         e_abort = 1'b0;
         if (w) begin
            q.push_back(sdrd);
            if (q.size() == BITS) begin
               for (int i = 0; i < BITS; i++) begin
                  wm[BITS-1-i] = q[i];
                  wl[i]        = q[i];
               end
               q.delete();
               done = 1'b1;
            end
         end else if (q.size() != 0) begin
            e_abort = 1'b1;
            q.delete();
         end
         e_busy = w;
         if (done) begin
            if (!e_v || data_ack) begin
               e_dm = wm; e_dl = wl; e_v = 1'b1;
            end else begin
               e_ovr = 1'b1;
            end
         end else begin
            if (e_v && data_ack) e_v = 1'b0;
            if (ovr_clr) e_ovr = 1'b0;
         end
         if (done && !(!e_v || data_ack) && 1'b0) e_ovr = 1'b1;
         if (done && ovr_clr && e_ovr == 1'b0) e_ovr = 1'b0;
      end
   end

   task automatic cyc(input logic w, input logic b, input logic a, input logic c);
      sser = ~w; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
      sdrd = b; data_ack = a; ovr_clr = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] wd, input logic ack_last, input logic clr_last);
      for (int i = 0; i < 8; i++)
         cyc(1'b1, wd[7-i], (i == 7) ? ack_last : 1'b0, (i == 7) ? clr_last : 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      n_chk++; if ({dm, dl} !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0", dm, dl); end
      n_chk++; if ({vm, vl, om, ol} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got v%b%b o%b%b want 0", vm, vl, om, ol); end
      n_chk++; if ({bm, bl, am, al} !== 4'b0) begin n_fail++; $display("FAIL reset_busy_abort: got b%b%b a%b%b want 0", bm, bl, am, al); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({am, al, bm, bl} !== 4'b0) begin n_fail++; $display("FAIL idle_no_abort: got a%b%b b%b%b want 0", am, al, bm, bl); end
   endtask

   task automatic test_single;
      logic [7:0] pat;
      pat = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, pat[7-i], 1'b0, 1'b0);
         if (i == 6) begin
            n_chk++; if (vm !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", vm); end
         end
      end
      n_chk++; if (dm !== 8'hB2) begin n_fail++; $display("FAIL single_msb: got %h want b2", dm); end
      n_chk++; if (dl !== 8'h4D) begin n_fail++; $display("FAIL single_lsb: got %h want 4d", dl); end
      n_chk++; if ({vm, vl, bm} !== 3'b111) begin n_fail++; $display("FAIL single_valid_busy: got %b%b%b want 111", vm, vl, bm); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n_chk++; if ({vm, vl, am, bm} !== 4'b0) begin n_fail++; $display("FAIL single_ack: got v%b%b a%b b%b want 0", vm, vl, am, bm); end
      n_chk++; if (dm !== 8'hB2) begin n_fail++; $display("FAIL single_hold: got %h want b2", dm); end
   endtask

   task automatic test_abort;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
      n_chk++; if ({bm, am} !== 2'b10) begin n_fail++; $display("FAIL abort_mid: got b%b a%b want b1 a0", bm, am); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({am, al, bm, vm} !== 4'b1100) begin n_fail++; $display("FAIL abort_pulse: got a%b%b b%b v%b want a11 b0 v0", am, al, bm, vm); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({am, al} !== 2'b00) begin n_fail++; $display("FAIL abort_width: got %b%b want 00", am, al); end
      send(8'hFF, 1'b0, 1'b0);
      n_chk++; if ({dm, dl, vm} !== {8'hFF, 8'hFF, 1'b1}) begin n_fail++; $display("FAIL abort_next_word: got %h/%h v%b want ff/ff v1", dm, dl, vm); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n_chk++; if (am !== 1'b0) begin n_fail++; $display("FAIL clean_boundary_abort: got %b want 0", am); end
   endtask

   task automatic test_overrun;
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      n_chk++; if ({dm, om, vm} !== {8'h11, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ovr_set: got %h o%b v%b want 11 o1 v1", dm, om, vm); end
      n_chk++; if ({dl, ol} !== {8'h88, 1'b1}) begin n_fail++; $display("FAIL ovr_lsb: got %h o%b want 88 o1", dl, ol); end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_chk++; if ({om, ol} !== 2'b00) begin n_fail++; $display("FAIL ovr_clr: got %b%b want 00", om, ol); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h33, 1'b0, 1'b0);
      n_chk++; if (dm !== 8'h33) begin n_fail++; $display("FAIL b2b_first: got %h want 33", dm); end
      send(8'h44, 1'b1, 1'b0);
      n_chk++; if ({dm, vm, om} !== {8'h44, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ack_on_complete: got %h v%b o%b want 44 v1 o0", dm, vm, om); end
      // Unacked word plus clear on the same edge as a drop: the set wins.
      send(8'h55, 1'b0, 1'b1);
      n_chk++; if ({dm, om} !== {8'h44, 1'b1}) begin n_fail++; $display("FAIL ovr_set_wins: got %h o%b want 44 o1", dm, om); end
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      n_chk++; if ({am, bm, vm} !== 3'b000) begin n_fail++; $display("FAIL rst_mid: got a%b b%b v%b want 0", am, bm, vm); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({am, al} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_no_abort: got %b%b want 00", am, al); end
      send(8'h5A, 1'b0, 1'b0);
      n_chk++; if ({dm, vm} !== {8'h5A, 1'b1}) begin n_fail++; $display("FAIL rst_mid_word: got %h v%b want 5a v1", dm, vm); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random;
      for (int n = 0; n < 1500; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         sser     = ($urandom_range(0, 9) == 0);
         ba13     = ($urandom_range(0, 19) == 0);
         ba12     = ($urandom_range(0, 19) != 0);
         br_w     = ($urandom_range(0, 19) != 0);
         sdrd     = 1'($urandom);
         data_ack = ($urandom_range(0, 3) == 0);
         ovr_clr  = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         @(negedge clk);
         n_chk++; if ({dm, dl} !== {e_dm, e_dl}) begin n_fail++; $display("FAIL rnd_data cyc%0d: got %h/%h want %h/%h", n, dm, dl, e_dm, e_dl); end
         n_chk++; if ({vm, vl, om, ol} !== {e_v, e_v, e_ovr, e_ovr}) begin n_fail++; $display("FAIL rnd_flags cyc%0d: got v%b%b o%b%b want v%b o%b", n, vm, vl, om, ol, e_v, e_ovr); end
         n_chk++; if ({am, al, bm, bl} !== {e_abort, e_abort, e_busy, e_busy}) begin n_fail++; $display("FAIL rnd_abort_busy cyc%0d: got a%b%b b%b%b want a%b b%b", n, am, al, bm, bl, e_abort, e_busy); end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sser = 1'b1; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
      sdrd = 1'b0; data_ack = 1'b0; ovr_clr = 1'b0;
      test_reset;
      test_single;
      test_abort;
      test_overrun;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
